branch_predictor: RTL and testbench

- Fetch-stage next-PC predictor: direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Fetch gets a same-cycle taken/target prediction.
- Execute reports each resolved branch/JAL/JALR outcome; the block trains its tables and issues a registered one-cycle redirect on mispredict.
- Successor to the combinational branch unit: adds state, parametrised width/depth, and mispredict recovery.

---
 rtl/branch_predictor.sv | 175 +++++++++++++++++
 tb/tb_branch_predictor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and registered mispredict redirect
// Optional BP_PERF_EN adds saturating control-flow and mispredict counters.
module branch_predictor #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [XLEN-1:0] i_fetchPC,
   output logic            o_predTake,
   output logic [XLEN-1:0] o_predPC,
   output logic            o_predHit,
   input  logic            i_updValid,
   input  logic [XLEN-1:0] i_updPC,
   input  logic            i_updIsBranch,
   input  logic            i_updIsJal,
   input  logic            i_updIsJalr,
   input  logic            i_updTake,
   input  logic [XLEN-1:0] i_updTarget,
   input  logic            i_updPredTake,
   input  logic [XLEN-1:0] i_updPredPC,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_redirectPC
`ifdef BP_PERF_EN
   ,
   output logic [31:0]     o_cfCount,
   output logic [31:0]     o_mispredCount
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);

   typedef enum logic [1:0] {
      TY_BR   = 2'd0,
      TY_JAL  = 2'd1,
      TY_JALR = 2'd2
   } cf_type_e;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [XLEN-1:0]    target_q [ENTRIES];
   logic [XLEN-1:0]    target_d [ENTRIES];
   cf_type_e           type_q   [ENTRIES];
   cf_type_e           type_d   [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];

   logic               redirect_q, redirect_d;
   logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;

   logic [IDX_W-1:0]   f_idx, u_idx;
   logic [TAG_W-1:0]   f_tag, u_tag;
   logic               pred_hit, pred_take;
   logic               upd_hit, upd_has_type, act_take, mis;
   cf_type_e           upd_type;

   assign f_idx = i_fetchPC[IDX_W+1:2];
   assign f_tag = i_fetchPC[IDX_W+TAG_W+1:IDX_W+2];
   assign u_idx = i_updPC[IDX_W+1:2];
   assign u_tag = i_updPC[IDX_W+TAG_W+1:IDX_W+2];

   // Lookup reads the registered tables, so a same-cycle update is not visible yet.
   always_comb begin
      pred_hit  = ~i_rst & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
      pred_take = pred_hit & ((type_q[f_idx] != TY_BR) | ctr_q[f_idx][1]);
   end

   assign o_predHit  = pred_hit;
   assign o_predTake = pred_take;
   assign o_predPC   = pred_take ? target_q[f_idx] : i_fetchPC + XLEN'(4);

   always_comb begin
      upd_has_type = i_updIsBranch | i_updIsJal | i_updIsJalr;
      act_take     = i_updTake | i_updIsJal | i_updIsJalr;
      upd_hit      = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
      if (i_updIsJalr)     upd_type = TY_JALR;
      else if (i_updIsJal) upd_type = TY_JAL;
      else                 upd_type = TY_BR;
      mis = (act_take != i_updPredTake) | (act_take & (i_updTarget != i_updPredPC));
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      type_d   = type_q;
      ctr_d    = ctr_q;
      if (i_updValid && upd_has_type) begin
         if (upd_hit) begin
            if (upd_type == TY_BR) begin
               if (act_take) begin
                  ctr_d[u_idx]    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
                  target_d[u_idx] = i_updTarget;
               end else begin
                  ctr_d[u_idx] = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
               end
            end else begin
               target_d[u_idx] = i_updTarget;
               type_d[u_idx]   = upd_type;
            end
         end else if (act_take) begin
            valid_d[u_idx]  = 1'b1;
            tag_d[u_idx]    = u_tag;
            target_d[u_idx] = i_updTarget;
            type_d[u_idx]   = upd_type;
            ctr_d[u_idx]    = (upd_type == TY_BR) ? 2'b10 : 2'b11;
         end
      end
   end

   always_comb begin
      redirect_d    = i_updValid & mis;
      redirect_pc_d = redirect_pc_q;
      if (redirect_d) begin
         redirect_pc_d = act_take ? i_updTarget : i_updPC + XLEN'(4);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q       <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            type_q[i]   <= TY_BR;
            ctr_q[i]    <= 2'b01;
         end
      end else begin
         valid_q       <= valid_d;
         tag_q         <= tag_d;
         target_q      <= target_d;
         type_q        <= type_d;
         ctr_q         <= ctr_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign o_redirect   = redirect_q;
   assign o_redirectPC = redirect_pc_q;

`ifdef BP_PERF_EN
   logic [31:0] cf_count_q, cf_count_d;
   logic [31:0] mispred_count_q, mispred_count_d;

   always_comb begin
      cf_count_d      = cf_count_q;
      mispred_count_d = mispred_count_q;
      if (i_updValid && upd_has_type && (cf_count_q != 32'hFFFF_FFFF)) begin
         cf_count_d = cf_count_q + 32'd1;
      end
      if (i_updValid && mis && (mispred_count_q != 32'hFFFF_FFFF)) begin
         mispred_count_d = mispred_count_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cf_count_q      <= '0;
         mispred_count_q <= '0;
      end else begin
         cf_count_q      <= cf_count_d;
         mispred_count_q <= mispred_count_d;
      end
   end

   assign o_cfCount      = cf_count_q;
   assign o_mispredCount = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor (16 entries, 8-bit tags)
module tb_branch_predictor;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_fetchPC;
   logic        o_predTake;
   logic [31:0] o_predPC;
   logic        o_predHit;
   logic        i_updValid;
   logic [31:0] i_updPC;
   logic        i_updIsBranch;
   logic        i_updIsJal;
   logic        i_updIsJalr;
   logic        i_updTake;
   logic [31:0] i_updTarget;
   logic        i_updPredTake;
   logic [31:0] i_updPredPC;
   logic        o_redirect;
   logic [31:0] o_redirectPC;
`ifdef BP_PERF_EN
   logic [31:0] o_cfCount;
   logic [31:0] o_mispredCount;
`endif

   always #5 i_clk = ~i_clk;

   branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_fetchPC(i_fetchPC),
      .o_predTake(o_predTake), .o_predPC(o_predPC), .o_predHit(o_predHit),
      .i_updValid(i_updValid), .i_updPC(i_updPC), .i_updIsBranch(i_updIsBranch),
      .i_updIsJal(i_updIsJal), .i_updIsJalr(i_updIsJalr), .i_updTake(i_updTake),
      .i_updTarget(i_updTarget), .i_updPredTake(i_updPredTake), .i_updPredPC(i_updPredPC),
      .o_redirect(o_redirect), .o_redirectPC(o_redirectPC)
`ifdef BP_PERF_EN
      , .o_cfCount(o_cfCount), .o_mispredCount(o_mispredCount)
`endif
   );

   typedef struct packed {
      logic        red;
      logic [31:0] pc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] last_rpc;
   int          checks = 0;
   int          errors = 0;

   task automatic step(input string name);
      exp_t e;
      @(posedge i_clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (o_redirect !== e.red || o_redirectPC !== e.pc) begin
         errors++;
         $display("FAIL %s redirect: got %b/%h expected %b/%h", name, o_redirect, o_redirectPC, e.red, e.pc);
      end
   endtask

   task automatic drive_upd(input logic [31:0] pc, input logic br, input logic jal, input logic jalr,
                            input logic take, input logic [31:0] tgt, input logic ptake,
                            input logic [31:0] ppc);
      i_updValid    = 1'b1;
      i_updPC       = pc;
      i_updIsBranch = br;
      i_updIsJal    = jal;
      i_updIsJalr   = jalr;
      i_updTake     = take;
      i_updTarget   = tgt;
      i_updPredTake = ptake;
      i_updPredPC   = ppc;
   endtask

   task automatic clear_upd();
      i_updValid    = 1'b0;
      i_updIsBranch = 1'b0;
      i_updIsJal    = 1'b0;
      i_updIsJalr   = 1'b0;
      i_updTake     = 1'b0;
   endtask

   task automatic upd(input string name, input logic [31:0] pc, input logic br, input logic jal,
                      input logic jalr, input logic take, input logic [31:0] tgt, input logic ptake,
                      input logic [31:0] ppc, input logic exp_red, input logic [31:0] exp_pc);
      drive_upd(pc, br, jal, jalr, take, tgt, ptake, ppc);
      if (exp_red) last_rpc = exp_pc;
      exp_q.push_back('{exp_red, last_rpc});
      step(name);
      clear_upd();
   endtask

   task automatic idle(input string name);
      exp_q.push_back('{1'b0, last_rpc});
      step(name);
   endtask

   task automatic chk_pred(input string name, input logic [31:0] pc, input logic eh,
                           input logic et, input logic [31:0] epc);
      i_fetchPC = pc;
      #1;
      checks++;
      if (o_predHit !== eh || o_predTake !== et || o_predPC !== epc) begin
         errors++;
         $display("FAIL %s pred: got hit=%b take=%b pc=%h expected hit=%b take=%b pc=%h",
                  name, o_predHit, o_predTake, o_predPC, eh, et, epc);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_fetchPC = 32'h100;
      clear_upd();
      i_updPC = '0; i_updTarget = '0; i_updPredTake = 1'b0; i_updPredPC = '0;
      #12;
      i_rst = 1'b0;
      last_rpc = 32'h0;
      chk_pred("reset_lookup", 32'h100, 1'b0, 1'b0, 32'h104);
      checks++;
      if (o_redirect !== 1'b0 || o_redirectPC !== 32'h0) begin
         errors++;
         $display("FAIL reset_redirect: got %b/%h expected 0/00000000", o_redirect, o_redirectPC);
      end
   endtask

   task automatic test_branch_train();
      upd("br_alloc", 32'h100, 1, 0, 0, 1, 32'h80, 0, 32'h104, 1'b1, 32'h80);
      idle("br_pulse_end");
      chk_pred("br_hit", 32'h100, 1'b1, 1'b1, 32'h80);
   endtask

   task automatic test_ctr_decay();
      upd("nt1", 32'h100, 1, 0, 0, 0, 32'h80, 1, 32'h80, 1'b1, 32'h104);
      chk_pred("ctr01", 32'h100, 1'b1, 1'b0, 32'h104);
      upd("nt2", 32'h100, 1, 0, 0, 0, 32'h80, 1, 32'h80, 1'b1, 32'h104);
      upd("nt3_sat", 32'h100, 1, 0, 0, 0, 32'h80, 0, 32'h104, 1'b0, 32'h0);
      upd("t_from00", 32'h100, 1, 0, 0, 1, 32'h80, 0, 32'h104, 1'b1, 32'h80);
      chk_pred("ctr_low_sat", 32'h100, 1'b1, 1'b0, 32'h104);
   endtask

   task automatic test_jalr();
      upd("jalr_ok", 32'h200, 0, 0, 1, 0, 32'h3000, 1, 32'h3000, 1'b0, 32'h0);
      chk_pred("jalr_pred1", 32'h200, 1'b1, 1'b1, 32'h3000);
      upd("jalr_tgt", 32'h200, 0, 0, 1, 0, 32'h4000, 1, 32'h3000, 1'b1, 32'h4000);
      chk_pred("jalr_pred2", 32'h200, 1'b1, 1'b1, 32'h4000);
   endtask

   task automatic test_jal_and_flags();
      upd("jal", 32'h304, 0, 1, 0, 0, 32'h1000, 0, 32'h308, 1'b1, 32'h1000);
      chk_pred("jal_pred", 32'h304, 1'b1, 1'b1, 32'h1000);
      upd("no_type", 32'h308, 0, 0, 0, 1, 32'h2000, 0, 32'h30C, 1'b1, 32'h2000);
      chk_pred("no_type_nowrite", 32'h308, 1'b0, 1'b0, 32'h30C);
      upd("prio_jalr", 32'h30C, 1, 0, 1, 0, 32'h700, 1, 32'h700, 1'b0, 32'h0);
      chk_pred("prio_alloc", 32'h30C, 1'b1, 1'b1, 32'h700);
   endtask

   task automatic test_aliasing();
      upd("alias_alloc", 32'h100, 1, 0, 0, 1, 32'h80, 0, 32'h104, 1'b1, 32'h80);
      chk_pred("alias_evict_200", 32'h200, 1'b0, 1'b0, 32'h204);
      chk_pred("alias_100", 32'h100, 1'b1, 1'b1, 32'h80);
      drive_upd(32'h140, 1, 0, 0, 1, 32'h500, 0, 32'h144);
      chk_pred("same_cycle_old", 32'h140, 1'b0, 1'b0, 32'h144);
      last_rpc = 32'h500;
      exp_q.push_back('{1'b1, last_rpc});
      step("alias_upd");
      clear_upd();
      chk_pred("alias_miss_100", 32'h100, 1'b0, 1'b0, 32'h104);
      chk_pred("alias_new_140", 32'h140, 1'b1, 1'b1, 32'h500);
   endtask

   task automatic test_back_to_back();
      upd("b2b_1", 32'h500, 0, 0, 0, 0, 32'h0, 1, 32'h900, 1'b1, 32'h504);
      upd("b2b_2", 32'h600, 0, 0, 0, 1, 32'h900, 1, 32'h800, 1'b1, 32'h900);
      idle("b2b_end");
      idle("b2b_hold");
   endtask

   task automatic test_wrap();
      chk_pred("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_reset_mid();
      drive_upd(32'h100, 1, 0, 0, 1, 32'hABC0, 0, 32'h104);
      #2;
      i_rst = 1'b1;
      #1;
      clear_upd();
      @(posedge i_clk);
      #1;
      checks++;
      if (o_redirect !== 1'b0 || o_redirectPC !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_redirect: got %b/%h expected 0/00000000", o_redirect, o_redirectPC);
      end
      i_rst = 1'b0;
      last_rpc = 32'h0;
      chk_pred("reset_mid_140", 32'h140, 1'b0, 1'b0, 32'h144);
      chk_pred("reset_mid_304", 32'h304, 1'b0, 1'b0, 32'h308);
`ifdef BP_PERF_EN
      checks++;
      if (o_cfCount !== 32'h0 || o_mispredCount !== 32'h0) begin
         errors++;
         $display("FAIL perf_reset: got %h/%h expected 0/0", o_cfCount, o_mispredCount);
      end
`endif
      idle("reset_mid_quiet");
   endtask

   initial begin
      test_reset();
      test_branch_train();
      test_ctr_decay();
      test_jalr();
      test_jal_and_flags();
      test_aliasing();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
